// File: rtl/mul_shift_add_cu.sv
// Sequential unsigned shift-and-add multiplier with start/done handshake; registers update on the falling edge of CLK.
// Optional build macro MUL_EARLY_EXIT_EN ends iteration as soon as the remaining multiplier bits are all zero.
module mul_shift_add_cu #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ADD   = 2'b01,
    S_DONE  = 2'b10,
    S_SPARE = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_shift;
  logic               add_last;

  // Product is 2*WIDTH bits wide, so this add can never carry out.
  assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shift = mplier_q >> 1;

`ifdef MUL_EARLY_EXIT_EN
  assign add_last = (count_q == CW'(WIDTH - 1)) || (mplier_shift == '0);
`else
  assign add_last = (count_q == CW'(WIDTH - 1));
`endif

  always_ff @(negedge CLK) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ADD;
      S_ADD:   if (add_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      S_ADD: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        count_d  = count_q + CW'(1);
        if (add_last) product_d = acc_sum;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == S_ADD);
    done = (state_q == S_DONE);
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul_shift_add_cu.sv
// Randomized self-checking bench for mul_shift_add_cu against an arithmetic reference (a*b and MSB-based latency).
module tb_mul_shift_add_cu;
  localparam int W = 8;

  logic           CLK;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  mul_shift_add_cu #(.WIDTH(W)) dut (
    .CLK(CLK), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  // clock/reset block: registers move on negedge, bench drives and samples on posedge
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_add_cycles(input logic [W-1:0] bv);
`ifdef MUL_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < W; i++) if (bv[i]) m = i;
    return m + 1;
`else
    return W;
`endif
  endfunction

  // driver: one multiply, optionally poking start with junk operands during ADD and DONE
  task automatic run_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit poke, input logic [W-1:0] pa, input logic [W-1:0] pb);
    int cyc;
    logic [2*W-1:0] e;
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    @(posedge CLK);
    start = 1'b1; a = av; b = bv;
    exp_q.push_back(prod);
    @(posedge CLK);
    cyc = 0;
    start = poke; a = pa; b = pb;
    while (busy === 1'b1 && cyc < 4 * W) begin
      cyc++;
      start = poke;
      a = poke ? pa : W'($urandom);
      b = poke ? pb : W'($urandom);
      @(posedge CLK);
    end
    e = exp_q.pop_front();
    check_eq("add_cycles", cyc, exp_add_cycles(bv));
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("busy_in_done", {31'd0, busy}, 32'd0);
    check_eq("product", {16'd0, product}, {16'd0, e});
    start = poke;
    @(posedge CLK);
    start = 1'b0;
    check_eq("done_one_cycle", {31'd0, done}, 32'd0);
    check_eq("busy_idle", {31'd0, busy}, 32'd0);
    check_eq("product_hold", {16'd0, product}, {16'd0, e});
  endtask

  initial begin
    int t, last, ndone, lat, exp_ndone;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge CLK);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_product", {16'd0, product}, 32'd0);
    reset = 1'b0;

    // directed operands
    run_mul(8'd13, 8'd11, 1'b0, 8'd0, 8'd0);
    run_mul(8'd255, 8'd255, 1'b0, 8'd0, 8'd0);
    run_mul(8'd0, 8'd200, 1'b0, 8'd0, 8'd0);
    run_mul(8'd7, 8'd9, 1'b1, 8'd3, 8'd3);
    run_mul(8'd200, 8'd1, 1'b0, 8'd0, 8'd0);
    run_mul(8'd3, 8'h10, 1'b0, 8'd0, 8'd0);
    run_mul(8'd2, 8'h80, 1'b0, 8'd0, 8'd0);

    // reset during the 4th ADD cycle discards the operation
    @(posedge CLK);
    start = 1'b1; a = 8'd100; b = 8'd50;
    @(posedge CLK);
    start = 1'b0;
    repeat (3) @(posedge CLK);
    reset = 1'b1;
    @(posedge CLK);
    reset = 1'b0;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_product", {16'd0, product}, 32'd0);
    @(posedge CLK);
    check_eq("midrst_idle_done", {31'd0, done}, 32'd0);
    check_eq("midrst_idle_busy", {31'd0, busy}, 32'd0);
    run_mul(8'd2, 8'd3, 1'b0, 8'd0, 8'd0);

    // back-to-back with start held high
    lat = exp_add_cycles(8'd6);
    exp_ndone = (60 - (lat + 1)) / (lat + 2) + 1;
    @(posedge CLK);
    start = 1'b1; a = 8'd5; b = 8'd6;
    last = -1; ndone = 0;
    for (t = 1; t <= 60; t++) begin
      @(posedge CLK);
      if (done === 1'b1) begin
        check_eq("b2b_product", {16'd0, product}, 32'd30);
        if (last >= 0) check_eq("b2b_period", t - last, lat + 2);
        else check_eq("b2b_first", t, lat + 1);
        last = t;
        ndone++;
      end
    end
    start = 1'b0;
    check_eq("b2b_count", ndone, exp_ndone);
    repeat (2 * W + 4) @(posedge CLK);

    // randomized operands and junk start pokes
    for (int i = 0; i < 25; i++) begin
      run_mul(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
              1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
